// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default operand width.
package serial_add_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int SA_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder; ovf exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_if import serial_add_pkg::*; #(
    parameter int WIDTH = SA_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_full_add.sv
// Single-bit full adder cell, purely combinational.
module full_add (
    output logic s,
    output logic c,
    input  logic x,
    input  logic y,
    input  logic cin
);
    assign s = x ^ y ^ cin;
    assign c = (x & y) | (x & cin) | (y & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder; optional signed-overflow output via SERIAL_ADD_OVF_EN.
// Latency: start-to-done WIDTH+1 clocks, one add per WIDTH+2 clocks.
// Backpressure: none; start is ignored (not queued) while busy or done is high.
module serial_adder import serial_add_pkg::*; #(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH:0]   w_res_ext;
    logic [WIDTH-1:0] w_res_next;

    full_add u_fa (.s(w_s), .c(w_c), .x(r_a_sh[0]), .y(r_b_sh[0]), .cin(r_carry));

    // New sum bit enters at the MSB; the concatenation keeps this legal for WIDTH=1.
    assign w_res_ext  = {w_s, r_res};
    assign w_res_next = w_res_ext[WIDTH:1];
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_OVF_EN
    logic r_cmsb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            r_cmsb  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_res   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_res   <= w_res_next;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    // Publish on the final bit so sum/cout are valid exactly when done rises.
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_c;
`ifdef SERIAL_ADD_OVF_EN
                        r_cmsb  <= r_carry;
`endif
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == ST_SHIFT);
    assign bus.done = (r_state == ST_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = r_cmsb ^ r_cout;
`endif
endmodule
